misr_sig_checker: RTL
=====================

MISR_SIG_CHECKER -- requirements
Module: misr_sig_checker

Interface
REQ-001 SHALL have parameter WORDS_W, default 16, meaning the width of the word-count field.
REQ-002 SHALL have port CK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: launches a check run; sampled only in IDLE or DONE.
REQ-005 SHALL have port abort, input, 1 bit: cancels a run in progress.
REQ-006 SHALL have port word_count, input, WORDS_W bits: number of words to compact; latched on start.
REQ-007 SHALL have port expected, input, 32 bits: golden signature; latched on start.
REQ-008 SHALL have port din_valid, input, 1 bit: the response word is valid.
REQ-009 SHALL have port din, input, 32 bits: response word; din[i] feeds signature bit i.
REQ-010 SHALL have port din_ready, output, 1 bit: the checker accepts a word this cycle.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN or CHECK.
REQ-012 SHALL have port done, output, 1 bit: high in DONE.
REQ-013 SHALL have port pass, output, 1 bit: comparison result; meaningful only while done=1.
REQ-014 SHALL have port signature, output, 32 bits: the current MISR contents.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN, CHECK, DONE.
REQ-016 IDLE/DONE with start=1 SHALL latch word_count and expected, clear signature to 0x00000000, clear pass, and go to RUN; if the latched count is 0, go to CHECK instead.
REQ-017 In RUN, din_ready SHALL be 1; a word SHALL be accepted only on a cycle with din_valid=1 and din_ready=1.
REQ-018 Each accepted word SHALL update the signature in one cycle, with fb=sig[31]:
- next[0] = NOT(fb XOR din[0]);
- next[i] = NOT(sig[i-1] XOR fb XOR din[i]) for i in {4,11,16};
- next[i] = NOT(sig[i-1] XOR din[i]) for every other i in 1..31.
REQ-019 No update SHALL occur on cycles without acceptance; the remaining count SHALL decrement by one per accepted word.
REQ-020 Acceptance of the last word SHALL move RUN to CHECK on the next edge; din_ready SHALL be 0 outside RUN.
REQ-021 CHECK SHALL last exactly one cycle, setting pass = (signature == latched expected), then go to DONE.
REQ-022 DONE SHALL hold signature and pass until start or RESET.
REQ-023 abort=1 in RUN or CHECK SHALL go to IDLE next cycle, with pass=0 and signature retained; abort SHALL have priority over acceptance in the same cycle.
REQ-024 start asserted in RUN or CHECK SHALL be ignored.
REQ-025 Latency from last acceptance to done=1 SHALL be 2 cycles.

Reset
REQ-026 RESET=1 at a rising edge SHALL force the following, regardless of state, including mid-run:
- state=IDLE;
- signature=0x00000000;
- pass=0, done=0, busy=0, din_ready=0;
- remaining count=0 and latched expected=0.

Structure
REQ-027 A shared package SHALL hold the state enum, the tap-set constant {4,11,16}, the width 32, and the signature reset value 0x00000000.
REQ-028 The MISR register plus next-state logic SHALL be one sub-module, misr32, with inputs clear, enable and data, and a 32-bit state output.

Verification
REQ-029 Reset, then start with count=1, din=0, expected=0xFFFFFFFF -> signature=0xFFFFFFFF; done=1 two cycles after acceptance, pass=1.
REQ-030 Count=3, din=0,0,0, expected=0xFFFDEFDF -> intermediate signatures 0xFFFFFFFF, 0x00010810, 0xFFFDEFDF; pass=1.
REQ-031 Same run with expected=0xFFFDEFDE -> pass=0, done=1.
REQ-032 Count=3 with din_valid toggling 1,0,0,1,1 -> exactly 3 acceptances, signature equal to the gap-free run.
REQ-033 Count=0 -> CHECK directly, signature=0; pass=1 iff expected=0x00000000.
REQ-034 RESET asserted after 1 accepted word of a count-3 run -> next cycle all outputs at reset values; a subsequent start behaves as from power-up.

Source files
------------

// File: rtl/misr_sig_checker_pkg.sv
// rtl/misr_sig_checker_pkg.sv - shared types and constants for the MISR signature checker
package misr_sig_checker_pkg;

  localparam int SIG_W = 32;
  localparam logic [SIG_W-1:0] SIG_RESET = 32'h0000_0000;

  localparam int NUM_TAPS = 3;
  localparam int TAPS [NUM_TAPS] = '{4, 11, 16};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_tap(input int bit_idx);
    logic hit;
    hit = 1'b0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      if (TAPS[t] == bit_idx) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/misr32.sv
// rtl/misr32.sv - 32-bit inverted-XOR MISR register with feedback from the top bit
module misr32
  import misr_sig_checker_pkg::*;
(
  input  logic             CK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             enable,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] state
);

  logic             fb;
  logic [SIG_W-1:0] next_sig;

  always_comb begin
    next_sig = '0;
    fb       = state[SIG_W-1];
    next_sig[0] = ~(fb ^ data[0]);
    for (int i = 1; i < SIG_W; i++) begin
      if (is_tap(i)) next_sig[i] = ~(state[i-1] ^ fb ^ data[i]);
      else           next_sig[i] = ~(state[i-1] ^ data[i]);
    end
  end

  always_ff @(posedge CK) begin
    if (RESET || clear) state <= SIG_RESET;
    else if (enable)    state <= next_sig;
  end

endmodule

// File: rtl/misr_sig_checker.sv
// rtl/misr_sig_checker.sv - compacts a counted word stream and compares against a golden signature
module misr_sig_checker
  import misr_sig_checker_pkg::*;
#(
  parameter int WORDS_W = 16
) (
  input  logic               CK,
  input  logic               RESET,
  input  logic               start,
  input  logic               abort,
  input  logic [WORDS_W-1:0] word_count,
  input  logic [SIG_W-1:0]   expected,
  input  logic               din_valid,
  input  logic [SIG_W-1:0]   din,
  output logic               din_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [SIG_W-1:0]   signature
);

  state_t             state_q, state_d;
  logic [WORDS_W-1:0] remaining_q, remaining_d;
  logic [SIG_W-1:0]   expected_q, expected_d;
  logic               pass_q, pass_d;
  logic               sig_clear;
  logic               accept;

  always_ff @(posedge CK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      expected_q  <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expected_q  <= expected_d;
      pass_q      <= pass_d;
    end
  end

  // abort wins over a same-cycle handshake, so the signature is left untouched
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expected_d  = expected_q;
    pass_d      = pass_q;
    sig_clear   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          remaining_d = word_count;
          expected_d  = expected;
          pass_d      = 1'b0;
          sig_clear   = 1'b1;
          state_d     = (word_count == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (din_valid) begin
          accept      = 1'b1;
          remaining_d = remaining_q - WORDS_W'(1);
          if (remaining_q == WORDS_W'(1)) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          pass_d  = (signature == expected_q);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  misr32 u_misr (
    .CK     (CK),
    .RESET  (RESET),
    .clear  (sig_clear),
    .enable (accept),
    .data   (din),
    .state  (signature)
  );

  assign din_ready = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;

endmodule
